// File: rtl/prog_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package prog_pkg;

  localparam int unsigned PC_W_DEFAULT = 10;
  localparam int unsigned LUT_N        = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  // Jump/branch targets; entry 2 is -3 in two's complement (backward branch).
  localparam logic [PC_W_DEFAULT-1:0] TARG_LUT [LUT_N] = '{
    10'd0, 10'd4, 10'h3FD, 10'd16
  };

  function automatic logic is_busy(input seq_state_t s);
    return (s == FETCH) || (s == EXEC) || (s == MEMWAIT);
  endfunction

endpackage

// File: rtl/prog_sequencer_targ_lut.sv
// Jump/branch target lookup: 2-bit TargSel index to a PC_W-wide target.
module targ_lut
  import prog_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [1:0]      sel,
  output logic [PC_W-1:0] targ_c
);

  // Sign-extend so negative offsets stay negative if PC_W is widened.
  always_comb targ_c = PC_W'($signed(TARG_LUT[sel]));

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC and gates decoder write enables.
// Optional macro PROG_SEQUENCER_CYCLE_COUNT_EN enables the busy-cycle counter.
module prog_sequencer
  import prog_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEFAULT,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Jump,
  input  logic            BranchEn,
  input  logic            BranchTaken,
  input  logic [1:0]      TargSel,
  input  logic            LoadInst,
  input  logic            MemWrEn,
  input  logic            RegWrEn,
  input  logic            AckIn,
  output logic [PC_W-1:0] PC,
  output logic            InstrValid,
  output logic            RegWrGate,
  output logic            MemWrGate,
  output logic            Busy,
  output logic            Done,
  output logic [15:0]     CycleCount
);

  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, done_q;
  logic              ivalid_c, reg_gate_c, mem_gate_c;
  logic [PC_W-1:0]   targ_c;

  targ_lut #(.PC_W(PC_W)) u_targ_lut (
    .sel    (TargSel),
    .targ_c (targ_c)
  );

  // Next-state, PC update and decoded write gates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_d     = wait_q;
    ivalid_c   = 1'b0;
    reg_gate_c = 1'b0;
    mem_gate_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        ivalid_c = 1'b1;
        if (AckIn) begin
          state_d = DONE;
        end else if (Jump) begin
          pc_d    = targ_c;
          state_d = FETCH;
        end else if (BranchEn) begin
          pc_d    = BranchTaken ? (pc_q + targ_c) : (pc_q + PC_W'(1));
          state_d = FETCH;
        end else if (LoadInst || MemWrEn) begin
          mem_gate_c = MemWrEn;
          wait_d     = WAIT_W'(MEM_LAT - 1);
          state_d    = MEMWAIT;
        end else begin
          reg_gate_c = RegWrEn;
          pc_d       = pc_q + PC_W'(1);
          state_d    = FETCH;
        end
      end
      MEMWAIT: begin
        // Load writeback lands only in the final wait cycle.
        if (wait_q == '0) begin
          reg_gate_c = LoadInst;
          pc_d       = pc_q + PC_W'(1);
          state_d    = FETCH;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      busy_q  <= is_busy(state_d);
      done_q  <= (state_d == DONE);
    end
  end

  assign PC         = pc_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign InstrValid = ivalid_c;
  assign RegWrGate  = reg_gate_c;
  assign MemWrGate  = mem_gate_c;

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
  logic [15:0] cyc_q;
  logic        start_acc;

  assign start_acc = ((state_q == IDLE) || (state_q == DONE)) && Start;

  // Saturating count of busy cycles, restarted by each accepted Start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc_q <= '0;
    end else if (start_acc) begin
      cyc_q <= '0;
    end else if (busy_q && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign CycleCount = cyc_q;
`else
  assign CycleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed program plus random instruction stream.
module tb_prog_sequencer;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned MEM_LAT = 2;
  localparam int          PC_MOD  = 1024;

  logic            Clk;
  logic            Reset_n;
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            Jump, BranchEn, BranchTaken;
  logic [1:0]      TargSel;
  logic            LoadInst, MemWrEn, RegWrEn, AckIn;
  logic [PC_W-1:0] PC;
  logic            InstrValid, RegWrGate, MemWrGate, Busy, Done;
  logic [15:0]     CycleCount;

  int checks   = 0;
  int failures = 0;
  int mpc      = 0;
  int exp_cyc  = 0;
  int lut [4]  = '{0, 4, -3, 16};

  prog_sequencer #(.PC_W(PC_W), .MEM_LAT(MEM_LAT)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Jump        (Jump),
    .BranchEn    (BranchEn),
    .BranchTaken (BranchTaken),
    .TargSel     (TargSel),
    .LoadInst    (LoadInst),
    .MemWrEn     (MemWrEn),
    .RegWrEn     (RegWrEn),
    .AckIn       (AckIn),
    .PC          (PC),
    .InstrValid  (InstrValid),
    .RegWrGate   (RegWrGate),
    .MemWrGate   (MemWrGate),
    .Busy        (Busy),
    .Done        (Done),
    .CycleCount  (CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic int cyc_exp();
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    return (exp_cyc > 65535) ? 65535 : exp_cyc;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Start = 1'b0; StartAddr = '0; Jump = 1'b0; BranchEn = 1'b0; BranchTaken = 1'b0;
    TargSel = 2'd0; LoadInst = 1'b0; MemWrEn = 1'b0; RegWrEn = 1'b0; AckIn = 1'b0;
  endtask

  // Called in an IDLE/DONE cycle; returns in the FETCH cycle of the first instruction.
  task automatic start_prog(input int addr);
    Start     = 1'b1;
    StartAddr = PC_W'(addr);
    step();
    Start   = 1'b0;
    mpc     = addr;
    exp_cyc = 0;
  endtask

  // Executes one instruction from its FETCH cycle; returns in the cycle after it retires.
  task automatic run_instr(input bit j, input bit br, input bit tk, input int sel,
                           input bit ld, input bit st, input bit rw, input bit ak);
    bit mem, alu, exp_rg, exp_mg;
    int lat, npc;
    mem = !ak && !j && !br && (ld || st);
    alu = !ak && !j && !br && !ld && !st;
    lat = mem ? 2 + MEM_LAT : 2;
    if (ak)      npc = mpc;
    else if (j)  npc = wrap(lut[sel]);
    else if (br) npc = tk ? wrap(mpc + lut[sel]) : wrap(mpc + 1);
    else         npc = wrap(mpc + 1);
    for (int k = 0; k < lat; k++) begin
      Jump = j; BranchEn = br; BranchTaken = tk; TargSel = 2'(sel);
      LoadInst = ld; MemWrEn = st; RegWrEn = rw; AckIn = ak;
      Start     = 1'($urandom_range(0, 1));
      StartAddr = PC_W'($urandom);
      #1;
      exp_rg = (alu && rw && k == 1) || (mem && ld && k == lat - 1);
      exp_mg = mem && st && k == 1;
      check("pc", 32'(PC), 32'(mpc));
      check("busy", 32'(Busy), 32'd1);
      check("done_low", 32'(Done), 32'd0);
      check("instr_valid", 32'(InstrValid), (k == 1) ? 32'd1 : 32'd0);
      check("reg_wr_gate", 32'(RegWrGate), 32'(exp_rg));
      check("mem_wr_gate", 32'(MemWrGate), 32'(exp_mg));
      check("cycle_count", 32'(CycleCount), 32'(cyc_exp()));
      exp_cyc++;
      step();
    end
    mpc = npc;
  endtask

  // Checks the DONE cycle that follows a halt.
  task automatic check_done();
    idle_inputs();
    #1;
    check("done", 32'(Done), 32'd1);
    check("done_busy", 32'(Busy), 32'd0);
    check("done_pc", 32'(PC), 32'(mpc));
    check("done_ivalid", 32'(InstrValid), 32'd0);
    check("done_regwr", 32'(RegWrGate), 32'd0);
    check("done_memwr", 32'(MemWrGate), 32'd0);
    check("done_cycles", 32'(CycleCount), 32'(cyc_exp()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(PC), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_ivalid"}, 32'(InstrValid), 32'd0);
    check({tag, "_regwr"}, 32'(RegWrGate), 32'd0);
    check({tag, "_memwr"}, 32'(MemWrGate), 32'd0);
    check({tag, "_cycles"}, 32'(CycleCount), 32'd0);
  endtask

  initial begin
    bit j, br, tk, ld, st, rw, ak;
    int sel;
    idle_inputs();
    Reset_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    step();
    #1;
    check_reset_outputs("idle_hold");

    // Directed program covering ALU, load, store, branches, jump and halt.
    start_prog(5);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0);   // ALU at 5 -> 6
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);   // ALU at 6 -> 7
    run_instr(0, 0, 0, 0, 1, 0, 1, 0);   // load at 7 -> 8
    run_instr(0, 0, 0, 0, 0, 1, 1, 0);   // store at 8 -> 9
    run_instr(0, 0, 0, 0, 0, 0, 1, 0);   // ALU at 9 -> 10
    run_instr(0, 1, 1, 2, 0, 0, 1, 0);   // taken branch -3 -> 7
    check("branch_taken_pc", 32'(mpc), 32'd7);
    run_instr(0, 0, 0, 0, 0, 0, 0, 1);   // halt at 7
    check_done();
    start_prog(10);
    run_instr(0, 1, 0, 2, 0, 0, 1, 0);   // not-taken branch -> 11
    run_instr(0, 0, 0, 3, 0, 0, 1, 0);   // ALU 11 -> 12
    run_instr(1, 0, 0, 3, 0, 0, 1, 0);   // jump LUT[3] -> 16
    run_instr(0, 0, 0, 0, 0, 0, 0, 1);
    check_done();
    start_prog(1023);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0);   // wraps to 0
    run_instr(0, 0, 0, 0, 0, 0, 0, 1);
    check_done();

    // ALU, load, halt: 2 + (2+MEM_LAT) + 2 busy cycles.
    start_prog(0);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0);
    run_instr(0, 0, 0, 0, 1, 0, 1, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 1);
    check_done();
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    check("cycle_count_prog", 32'(CycleCount), 32'd8);
`endif

    // Random instruction stream with occasional halts and restarts.
    start_prog(int'($urandom_range(0, 1023)));
    for (int i = 0; i < 80; i++) begin
      j   = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 3) == 0);
      tk  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      ld  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rw  = 1'($urandom_range(0, 1));
      ak  = ($urandom_range(0, 9) == 0);
      run_instr(j, br, tk, sel, ld, st, rw, ak);
      if (ak) begin
        check_done();
        start_prog(int'($urandom_range(0, 1023)));
      end
    end
    run_instr(0, 0, 0, 0, 0, 0, 0, 1);
    check_done();

    // Reset in the load writeback cycle drops the gate immediately.
    start_prog(200);
    idle_inputs();
    LoadInst = 1'b1; RegWrEn = 1'b1;
    repeat (1 + MEM_LAT) step();
    #1;
    check("load_wb_before_reset", 32'(RegWrGate), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_memwait");
    repeat (2) step();
    check_reset_outputs("rst_hold");
    Reset_n = 1'b1;

    // Reset during a store's EXEC cycle.
    step();
    start_prog(300);
    idle_inputs();
    MemWrEn = 1'b1;
    step();
    #1;
    check("store_gate_before_reset", 32'(MemWrGate), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    Reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
